sd_block_reader: RTL and testbench

- Sequencer that drives the SPI master's register interface (enable/rnw/addr/din/dout) to read one 512-byte SD card block with CMD17.
- Streams the data bytes out one at a time with a valid strobe.
- Sits between the SPI master and a block-buffer or DMA client, which frees the 6502 from byte-level SD polling.
- The card must already be initialised (CMD0/CMD8/ACMD41 done, SPI master out of its power-up init phase) before start is issued.

---
 rtl/sd_block_reader_if.sv | 17 +
 rtl/sd_block_reader.sv | 247 ++++++++++++++++++++++++
 tb/tb_sd_block_reader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | sd_block_reader_if : register-port bundle toward the SPI master  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface sd_block_reader_if;
  logic       spi_enable;
  logic       spi_rnw;
  logic [2:0] spi_addr;
  logic [7:0] spi_din;
  logic [7:0] spi_dout;

  modport master (output spi_enable, spi_rnw, spi_addr, spi_din, input spi_dout);
  modport slave  (input spi_enable, spi_rnw, spi_addr, spi_din, output spi_dout);
endinterface
`default_nettype wire

// File: rtl/sd_block_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | sd_block_reader : CMD17 single-block read sequencer, streams the |
// | 512 data bytes out with a valid strobe                           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sd_block_reader #(
  parameter int unsigned XFER_WAIT = 20,
  parameter int unsigned NCR_MAX   = 16,
  parameter int unsigned TOKEN_MAX = 4096,
  parameter bit          BYTE_ADDR = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [31:0]              block_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [7:0]               data_out,
  output logic                     data_valid,
  sd_block_reader_if.master        spi
);

  localparam int unsigned WAIT_W = $clog2(XFER_WAIT + 1);
  localparam int unsigned NCR_W  = $clog2(NCR_MAX + 1);
  localparam int unsigned TOK_W  = $clog2(TOKEN_MAX + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(XFER_WAIT);
  localparam logic [WAIT_W-1:0] C_WAIT_ONE  = WAIT_W'(1);
  localparam logic [NCR_W-1:0]  C_NCR_LAST  = NCR_W'(NCR_MAX - 1);
  localparam logic [TOK_W-1:0]  C_TOK_LAST  = TOK_W'(TOKEN_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CS_LOW, S_PRE, S_CMD, S_R1_POLL, S_TOK_POLL, S_DATA,
    S_CRC, S_CS_HIGH, S_TRAIL, S_FINISH, S_ABORT_CS, S_ABORT_XCHG
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [2:0]         idx_q, idx_d;
  logic [NCR_W-1:0]   ncr_q, ncr_d;
  logic [TOK_W-1:0]   tok_q, tok_d;
  logic [8:0]         byte_q, byte_d;
  logic [31:0]        arg_q, arg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;

  logic               is_cs;
  logic               is_xchg;
  logic               step_done;
  logic               spi_en;
  logic [2:0]         spi_sel;
  logic [7:0]         spi_byte;
  logic [7:0]         cmd_byte;

  always_comb begin
    is_cs   = (state_q == S_CS_LOW) || (state_q == S_CS_HIGH) || (state_q == S_ABORT_CS);
    is_xchg = (state_q == S_PRE) || (state_q == S_CMD) || (state_q == S_R1_POLL) ||
              (state_q == S_TOK_POLL) || (state_q == S_DATA) || (state_q == S_CRC) ||
              (state_q == S_TRAIL) || (state_q == S_ABORT_XCHG);
    // CS writes need only one settling cycle; byte exchanges wait for the shift to finish
    step_done = is_cs ? (wait_q == C_WAIT_ONE) : (is_xchg && (wait_q == C_WAIT_LAST));

    case (idx_q)
      3'd0:    cmd_byte = 8'h51;
      3'd1:    cmd_byte = arg_q[31:24];
      3'd2:    cmd_byte = arg_q[23:16];
      3'd3:    cmd_byte = arg_q[15:8];
      3'd4:    cmd_byte = arg_q[7:0];
      default: cmd_byte = 8'hFF;
    endcase

    spi_en   = (is_cs || is_xchg) && (wait_q == '0);
    spi_sel  = 3'd0;
    spi_byte = 8'hFF;
    if (spi_en) begin
      case (state_q)
        S_CS_LOW:               spi_sel = 3'd4;
        S_CS_HIGH, S_ABORT_CS:  spi_sel = 3'd3;
        S_CMD:                  spi_sel = 3'd0;
        default:                spi_sel = 3'd1;
      endcase
      if (state_q == S_CMD) spi_byte = cmd_byte;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    idx_d        = idx_q;
    ncr_d        = ncr_q;
    tok_d        = tok_q;
    byte_d       = byte_q;
    arg_d        = arg_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    err_code_d   = err_code_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;

    if (is_cs || is_xchg) wait_d = step_done ? '0 : wait_q + C_WAIT_ONE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          arg_d      = BYTE_ADDR ? {block_addr[22:0], 9'd0} : block_addr;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          err_code_d = 2'd0;
          wait_d     = '0;
          idx_d      = 3'd0;
          ncr_d      = '0;
          tok_d      = '0;
          byte_d     = 9'd0;
          state_d    = S_CS_LOW;
        end
      end
      S_CS_LOW: if (step_done) state_d = S_PRE;
      S_PRE:    if (step_done) state_d = S_CMD;
      S_CMD: begin
        if (step_done) begin
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = S_R1_POLL;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_R1_POLL: begin
        if (step_done) begin
          if (spi.spi_dout != 8'hFF) begin
            if (spi.spi_dout == 8'h00) begin
              state_d = S_TOK_POLL;
            end else begin
              err_code_d = 2'd2;
              state_d    = S_ABORT_CS;
            end
          end else if (ncr_q == C_NCR_LAST) begin
            err_code_d = 2'd1;
            state_d    = S_ABORT_CS;
          end else begin
            ncr_d = ncr_q + NCR_W'(1);
          end
        end
      end
      S_TOK_POLL: begin
        if (step_done) begin
          if (spi.spi_dout == 8'hFE) begin
            state_d = S_DATA;
          end else if ((spi.spi_dout != 8'hFF) || (tok_q == C_TOK_LAST)) begin
            err_code_d = 2'd3;
            state_d    = S_ABORT_CS;
          end else begin
            tok_d = tok_q + TOK_W'(1);
          end
        end
      end
      S_DATA: begin
        if (step_done) begin
          data_out_d   = spi.spi_dout;
          data_valid_d = 1'b1;
          byte_d       = byte_q + 9'd1;
          if (byte_q == 9'd511) state_d = S_CRC;
        end
      end
      S_CRC: begin
        if (step_done) begin
          if (idx_q == 3'd1) begin
            idx_d   = 3'd0;
            state_d = S_CS_HIGH;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_CS_HIGH:  if (step_done) state_d = S_TRAIL;
      S_TRAIL:    if (step_done) state_d = S_FINISH;
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ABORT_CS: if (step_done) state_d = S_ABORT_XCHG;
      S_ABORT_XCHG: begin
        if (step_done) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      idx_q        <= 3'd0;
      ncr_q        <= '0;
      tok_q        <= '0;
      byte_q       <= 9'd0;
      arg_q        <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 2'd0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      idx_q        <= idx_d;
      ncr_q        <= ncr_d;
      tok_q        <= tok_d;
      byte_q       <= byte_d;
      arg_q        <= arg_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_code       = err_code_q;
  assign data_out       = data_out_q;
  assign data_valid     = data_valid_q;
  assign spi.spi_enable = spi_en;
  assign spi.spi_rnw    = ~spi_en;
  assign spi.spi_addr   = spi_sel;
  assign spi.spi_din    = spi_byte;

endmodule
`default_nettype wire

// File: tb/tb_sd_block_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sd_block_reader : scripted SD card against sd_block_reader    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_sd_block_reader;
  localparam int XFER_WAIT = 20;
  localparam int NCR_MAX   = 16;
  localparam int TOKEN_MAX = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] block_addr = 32'd0;
  logic        busy, done, error, data_valid;
  logic [1:0]  err_code;
  logic [7:0]  data_out;
  sd_block_reader_if bus ();

  logic        start_ba = 1'b0;
  logic [31:0] block_addr_ba = 32'd0;
  logic        busy_ba, done_ba, error_ba, data_valid_ba;
  logic [1:0]  err_code_ba;
  logic [7:0]  data_out_ba;
  sd_block_reader_if bus_ba ();
  assign bus_ba.spi_dout = 8'hFF;

  always #5 clk = ~clk;

  sd_block_reader #(.XFER_WAIT(XFER_WAIT), .NCR_MAX(NCR_MAX), .TOKEN_MAX(TOKEN_MAX), .BYTE_ADDR(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .block_addr(block_addr), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .data_out(data_out), .data_valid(data_valid), .spi(bus));

  sd_block_reader #(.XFER_WAIT(XFER_WAIT), .NCR_MAX(NCR_MAX), .TOKEN_MAX(TOKEN_MAX), .BYTE_ADDR(1'b1)) dut_ba (
    .clk(clk), .reset(reset), .start(start_ba), .block_addr(block_addr_ba), .busy(busy_ba), .done(done_ba),
    .error(error_ba), .err_code(err_code_ba), .data_out(data_out_ba), .data_valid(data_valid_ba), .spi(bus_ba));

  typedef struct {
    logic [31:0] addr;
    int          r1_delay;
    logic [7:0]  r1;
    int          tok_delay;
    logic [7:0]  token;
    bit          rnd_data;
    bit          mid_start;
    int          rst_at;
    int          exp_err;
    int          exp_done;
  } scen_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt;
  int rnw_viol;
  logic [7:0]  resp_q[$];
  logic [10:0] wr_q[$];
  int          wr_t[$];
  logic [7:0]  data_q[$];
  logic [10:0] ba_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // one clock: the card answers each byte exchange, the bus and stream are logged
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.spi_enable) begin
      if (bus.spi_rnw !== 1'b0) rnw_viol++;
      wr_q.push_back({bus.spi_addr, bus.spi_din});
      wr_t.push_back(cyc);
      if (bus.spi_addr <= 3'd1) bus.spi_dout = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hFF;
    end
    if (data_valid) data_q.push_back(data_out);
    if (done) done_cnt++;
    if (bus_ba.spi_enable) ba_q.push_back({bus_ba.spi_addr, bus_ba.spi_din});
  endtask

  task automatic run_scen(input scen_t s, input int id);
    logic [7:0]  exp_data[$];
    logic [10:0] exp_wr[$];
    int n_r1, wr_bad, gap_bad, data_bad, lim;
    bit pulsed;
    string tag;
    tag = $sformatf("s%0d", id);
    for (int i = 0; i < 512; i++) exp_data.push_back(s.rnd_data ? 8'($urandom) : 8'(i));

    resp_q.delete();
    for (int i = 0; i < 7; i++) resp_q.push_back(8'hFF);
    for (int i = 0; i < s.r1_delay; i++) resp_q.push_back(8'hFF);
    resp_q.push_back(s.r1);
    for (int i = 0; i < s.tok_delay; i++) resp_q.push_back(8'hFF);
    resp_q.push_back(s.token);
    foreach (exp_data[i]) resp_q.push_back(exp_data[i]);

    exp_wr.push_back({3'd4, 8'hFF});
    exp_wr.push_back({3'd1, 8'hFF});
    exp_wr.push_back({3'd0, 8'h51});
    for (int b = 3; b >= 0; b--) exp_wr.push_back({3'd0, 8'(s.addr >> (8 * b))});
    exp_wr.push_back({3'd0, 8'hFF});
    n_r1 = (s.r1_delay >= NCR_MAX) ? NCR_MAX : s.r1_delay + 1;
    for (int i = 0; i < n_r1; i++) exp_wr.push_back({3'd1, 8'hFF});
    if (s.r1_delay < NCR_MAX && s.r1 == 8'h00) begin
      for (int i = 0; i <= s.tok_delay; i++) exp_wr.push_back({3'd1, 8'hFF});
      if (s.token == 8'hFE) for (int i = 0; i < 514; i++) exp_wr.push_back({3'd1, 8'hFF});
    end
    exp_wr.push_back({3'd3, 8'hFF});
    exp_wr.push_back({3'd1, 8'hFF});

    wr_q.delete(); wr_t.delete(); data_q.delete();
    done_cnt = 0; rnw_viol = 0; pulsed = 1'b0;
    start = 1'b1; block_addr = s.addr;
    tick();
    start = 1'b0;
    check({tag, " busy_after_start"}, busy, 1);
    check({tag, " error_cleared"}, error, 0);
    check({tag, " err_code_cleared"}, err_code, 0);

    lim = 0;
    while (busy && lim < 20000) begin
      start = 1'b0;
      if (s.mid_start && !pulsed && data_q.size() == 50) begin
        start = 1'b1; block_addr = 32'hFFFF_FFFF; pulsed = 1'b1;
      end
      if (s.rst_at > 0 && data_q.size() == s.rst_at) begin
        reset = 1'b1;
        tick();
        check({tag, " rst_busy"}, busy, 0);
        check({tag, " rst_spi_enable"}, bus.spi_enable, 0);
        check({tag, " rst_data_valid"}, data_valid, 0);
        data_bad = 0;
        foreach (data_q[i]) if (data_q[i] !== exp_data[i]) data_bad++;
        check({tag, " prefix_data_errors"}, data_bad, 0);
        reset = 1'b0;
        tick();
        return;
      end
      tick();
      lim++;
    end
    start = 1'b0;
    check({tag, " finished_in_budget"}, busy, 0);
    tick(); tick();

    check({tag, " err_code"}, err_code, s.exp_err);
    check({tag, " error"}, error, (s.exp_err != 0));
    check({tag, " done_pulses"}, done_cnt, s.exp_done);
    check({tag, " rnw_low_on_write"}, rnw_viol, 0);
    check({tag, " write_count"}, wr_q.size(), exp_wr.size());
    wr_bad = 0; gap_bad = 0;
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
      if (wr_q[i][10:8] !== exp_wr[i][10:8] || (exp_wr[i][10:8] == 3'd0 && wr_q[i][7:0] !== exp_wr[i][7:0])) begin
        if (wr_bad == 0) $display("FAIL %s write[%0d]: actual=0x%0h required=0x%0h", tag, i, wr_q[i], exp_wr[i]);
        wr_bad++;
      end
      if (i > 0) begin
        if (wr_t[i] - wr_t[i-1] != ((wr_q[i-1][10:8] >= 3'd3) ? 2 : XFER_WAIT + 1)) gap_bad++;
      end
    end
    check({tag, " write_errors"}, wr_bad, 0);
    check({tag, " write_spacing_errors"}, gap_bad, 0);
    check({tag, " data_count"}, data_q.size(), (s.exp_done != 0) ? 512 : 0);
    data_bad = 0;
    for (int i = 0; i < data_q.size() && i < 512; i++) if (data_q[i] !== exp_data[i]) data_bad++;
    check({tag, " data_errors"}, data_bad, 0);
  endtask

  initial begin
    scen_t tab[9];
    logic [7:0] ba_exp[6];
    int lim;
    tab[0] = '{32'h0000_1234, 2,  8'h00, 3,  8'hFE, 1'b0, 1'b0, -1, 0, 1};
    tab[1] = '{32'hABCD_0001, 0,  8'h05, 0,  8'hFE, 1'b0, 1'b0, -1, 2, 0};
    tab[2] = '{32'h0000_0001, 100, 8'h00, 0, 8'hFE, 1'b0, 1'b0, -1, 1, 0};
    tab[3] = '{32'h0000_0002, 1,  8'h00, 2,  8'hFC, 1'b0, 1'b0, -1, 3, 0};
    tab[4] = '{$urandom, int'($urandom_range(0, 14)), 8'h00, int'($urandom_range(0, 40)), 8'hFE, 1'b1, 1'b1, -1, 0, 1};
    tab[5] = '{32'h00FF_00FF, 15, 8'h00, 0,  8'hFE, 1'b0, 1'b0, -1, 0, 1};
    tab[6] = '{32'h0000_0005, 16, 8'h00, 0,  8'hFE, 1'b0, 1'b0, -1, 1, 0};
    tab[7] = '{32'h0000_0077, 0,  8'h00, 0,  8'hFE, 1'b0, 1'b0, 100, 0, 0};
    tab[8] = '{32'hDEAD_BEEF, 1,  8'h00, 1,  8'hFE, 1'b1, 1'b0, -1, 0, 1};
    ba_exp = '{8'h51, 8'h00, 8'h00, 8'h06, 8'h00, 8'hFF};

    bus.spi_dout = 8'hFF;
    done_cnt = 0; rnw_viol = 0;
    repeat (3) tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset err_code", err_code, 0);
    check("reset data_out", data_out, 8'h00);
    check("reset data_valid", data_valid, 0);
    check("reset spi_enable", bus.spi_enable, 0);
    check("reset spi_rnw", bus.spi_rnw, 1);
    check("reset spi_addr", bus.spi_addr, 0);
    check("reset spi_din", bus.spi_din, 8'hFF);

    start = 1'b1;
    tick();
    check("start_with_reset busy", busy, 0);
    check("start_with_reset spi_enable", bus.spi_enable, 0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("start_with_reset stays idle", busy, 0);

    foreach (tab[i]) run_scen(tab[i], i);

    ba_q.delete();
    block_addr_ba = 32'h0000_0003; start_ba = 1'b1;
    tick();
    start_ba = 1'b0;
    lim = 0;
    while (busy_ba && lim < 5000) begin tick(); lim++; end
    check("ba finished_in_budget", busy_ba, 0);
    check("ba write_count", ba_q.size(), 2 + 6 + NCR_MAX + 2);
    for (int i = 0; i < 6; i++)
      if (ba_q.size() > i + 2) check($sformatf("ba cmd_byte%0d", i), ba_q[i+2], {3'd0, ba_exp[i]});
    check("ba err_code", err_code_ba, 1);
    check("ba done", done_ba, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
